// File: rtl/param_loader_pkg.sv
// Shared constants and types for the host-link parameter loader.
// Frame: header, three 24-bit big-endian fields, XOR checksum.
package param_loader_pkg;
    localparam logic [7:0] FRAME_HDR     = 8'hA5;
    localparam int         PAYLOAD_BYTES = 9;
    localparam int         PARAM_W       = 18;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } state_t;
endpackage

// File: rtl/gap_timer.sv
// Idle-gap counter for in-frame byte spacing.
// The expire output fires on the TIMEOUT-th consecutive idle cycle unless a byte arrives then.
module gap_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || !en)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // A byte in the expiry cycle restarts the gap instead of aborting.
    assign expire = en && !clr && (cnt == LAST);
endmodule

// File: rtl/param_loader.sv
// Assembles framed mu/S/sigma parameters from the host byte stream and
// presents them atomically to the risk core; only fully valid frames update outputs.
module param_loader
    import param_loader_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         iByte,
    input  logic               iByteValid,
    output logic [PARAM_W-1:0] oMu,
    output logic [PARAM_W-1:0] oS,
    output logic [PARAM_W-1:0] oSigma,
    output logic               oLoad,
    output logic               oBusy,
    output logic [7:0]         oErrCnt
);
    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

    state_t      state, state_n;
    logic [3:0]  idx;
    logic [71:0] shadow;
    logic [7:0]  csum;
    logic        expire;
    logic        rsvd_ok;
    logic        take_good;
    logic        take_err;

    gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
        .clk    (CLK),
        .rst    (RST),
        .clr    (iByteValid),
        .en     (state != HUNT),
        .expire (expire)
    );

    assign rsvd_ok = (shadow[71:66] == '0) && (shadow[47:42] == '0) && (shadow[23:18] == '0);
    assign oBusy   = (state != HUNT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= HUNT;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        take_good = 1'b0;
        take_err  = 1'b0;
        case (state)
            HUNT: begin
                if (iByteValid && iByte == FRAME_HDR)
                    state_n = PAYLOAD;
            end
            PAYLOAD: begin
                if (iByteValid) begin
                    if (idx == LAST_IDX)
                        state_n = CHECK;
                end else if (expire) begin
                    state_n  = HUNT;
                    take_err = 1'b1;
                end
            end
            CHECK: begin
                if (iByteValid) begin
                    state_n = HUNT;
                    if (iByte == csum && rsvd_ok)
                        take_good = 1'b1;
                    else
                        take_err = 1'b1;
                end else if (expire) begin
                    state_n  = HUNT;
                    take_err = 1'b1;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx     <= '0;
            shadow  <= '0;
            csum    <= '0;
            oMu     <= '0;
            oS      <= '0;
            oSigma  <= '0;
            oLoad   <= 1'b0;
            oErrCnt <= '0;
        end else begin
            oLoad <= take_good;
            if (state == HUNT && iByteValid && iByte == FRAME_HDR) begin
                idx    <= '0;
                csum   <= '0;
                shadow <= '0;
            end else if (state == PAYLOAD && iByteValid) begin
                shadow <= {shadow[63:0], iByte};
                csum   <= csum ^ iByte;
                idx    <= idx + 4'd1;
            end
            if (take_good) begin
                oMu    <= shadow[48 +: PARAM_W];
                oS     <= shadow[24 +: PARAM_W];
                oSigma <= shadow[0  +: PARAM_W];
            end
            if (take_err) begin
                shadow <= '0;
                if (oErrCnt != 8'hFF)
                    oErrCnt <= oErrCnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_param_loader.sv
// Scoreboard bench for param_loader: expected parameter sets are queued as
// frames are driven and matched against each oLoad pulse.
module tb_param_loader;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  iByte = 8'h00;
    logic        iByteValid = 1'b0;
    logic [17:0] oMu, oS, oSigma;
    logic        oLoad, oBusy;
    logic [7:0]  oErrCnt;

    typedef struct packed {
        logic [17:0] mu;
        logic [17:0] s;
        logic [17:0] sigma;
    } pset_t;

    pset_t       exp_q[$];
    pset_t       cur;
    logic [7:0]  exp_err;
    int          n_vec = 0;
    int          n_err = 0;

    param_loader #(.TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .iByte(iByte), .iByteValid(iByteValid),
        .oMu(oMu), .oS(oS), .oSigma(oSigma), .oLoad(oLoad), .oBusy(oBusy),
        .oErrCnt(oErrCnt)
    );

    always #5 CLK = ~CLK;

    // Every load pulse must match the oldest outstanding good frame.
    always @(negedge CLK) begin
        if (!RST && oLoad) begin
            pset_t e;
            pset_t got;
            got = '{mu: oMu, s: oS, sigma: oSigma};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_load: got mu=%0d s=%0d sigma=%0d, expected no load", oMu, oS, oSigma);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL load_value: got mu=%0d s=%0d sigma=%0d, expected mu=%0d s=%0d sigma=%0d",
                             oMu, oS, oSigma, e.mu, e.s, e.sigma);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        iByte = b;
        iByteValid = 1'b1;
        @(posedge CLK);
        #1;
        iByteValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        exp_q.delete();
        cur = '0;
        exp_err = 8'd0;
        idle(2);
        RST = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] m, input logic [23:0] s, input logic [23:0] sg,
                              input bit corrupt);
        logic [71:0] pl;
        logic [7:0]  b[11];
        logic [7:0]  ck;
        bit          good;
        pl = {m, s, sg};
        b[0] = 8'hA5;
        ck = 8'h00;
        for (int i = 0; i < 9; i++) begin
            b[i+1] = pl[71-8*i -: 8];
            ck ^= b[i+1];
        end
        b[10] = corrupt ? (ck ^ 8'h01) : ck;
        good = !corrupt && m[23:18] == 6'd0 && s[23:18] == 6'd0 && sg[23:18] == 6'd0;
        if (good) begin
            cur = '{mu: m[17:0], s: s[17:0], sigma: sg[17:0]};
            exp_q.push_back(cur);
        end else if (exp_err != 8'hFF) begin
            exp_err = exp_err + 8'd1;
        end
        for (int i = 0; i < 11; i++) send(b[i]);
    endtask

    task automatic check_settled(input string tag);
        idle(1);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_pending: %0d loads missing, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        n_vec++;
        if ({oMu, oS, oSigma} !== {cur.mu, cur.s, cur.sigma}) begin
            n_err++;
            $display("FAIL %s_outputs: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                     tag, oMu, oS, oSigma, cur.mu, cur.s, cur.sigma);
        end
        n_vec++;
        if (oErrCnt !== exp_err) begin
            n_err++;
            $display("FAIL %s_errcnt: got %0d, expected %0d", tag, oErrCnt, exp_err);
        end
    endtask

    task automatic test_reset();
        cur = '0;
        #2;
        n_vec++;
        if ({oMu, oS, oSigma, oLoad, oBusy, oErrCnt} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_values: got %h, expected 0", {oMu, oS, oSigma, oLoad, oBusy, oErrCnt});
        end
        apply_reset();
    endtask

    task automatic test_good();
        send_frame(24'h0000B8, 24'h006000, 24'h000D50, 1'b0);
        check_settled("good");
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        send_frame(24'h0000B8, 24'h006000, 24'h000D50, 1'b1);
        check_settled("bad_cksum");
    endtask

    task automatic test_reserved();
        send_frame(24'h0400B8, 24'h006000, 24'h000D50, 1'b0);
        check_settled("reserved");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send(8'h11);
        send(8'h22);
        send_frame(24'h0000B8, 24'h006000, 24'h000D50, 1'b0);
        send_frame(24'h000001, 24'h006000, 24'h000D50, 1'b0);
        check_settled("b2b");
    endtask

    task automatic test_timeout();
        send(8'hA5);
        for (int i = 0; i < 4; i++) send(8'h00);
        idle(15);
        n_vec++;
        if (oBusy !== 1'b1 || oErrCnt !== exp_err) begin
            n_err++;
            $display("FAIL timeout_early: got busy=%0d err=%0d, expected busy=1 err=%0d", oBusy, oErrCnt, exp_err);
        end
        idle(1);
        exp_err = exp_err + 8'd1;
        n_vec++;
        if (oBusy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_busy: got %0d, expected 0", oBusy);
        end
        check_settled("timeout");
        send_frame(24'h000123, 24'h000456, 24'h000789, 1'b0);
        check_settled("after_timeout");
    endtask

    task automatic test_timeout_boundary();
        logic [71:0] pl;
        logic [7:0]  ck;
        pl = {24'h000007, 24'h000100, 24'h020000};
        ck = 8'h00;
        for (int i = 0; i < 9; i++) ck ^= pl[71-8*i -: 8];
        cur = '{mu: 18'd7, s: 18'h100, sigma: 18'h20000};
        exp_q.push_back(cur);
        send(8'hA5);
        for (int i = 0; i < 4; i++) send(pl[71-8*i -: 8]);
        idle(15);
        for (int i = 4; i < 9; i++) send(pl[71-8*i -: 8]);
        n_vec++;
        if (oBusy !== 1'b1) begin
            n_err++;
            $display("FAIL boundary_busy: got %0d, expected 1", oBusy);
        end
        send(ck);
        check_settled("boundary");
    endtask

    task automatic test_reset_midframe();
        send(8'hA5);
        for (int i = 0; i < 5; i++) send(8'h00);
        #2;
        RST = 1'b1;
        #1;
        n_vec++;
        if (oBusy !== 1'b0 || oErrCnt !== 8'd0 || oMu !== 18'd0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%0d err=%0d mu=%0d, expected 0/0/0", oBusy, oErrCnt, oMu);
        end
        apply_reset();
        send_frame(24'h0000B8, 24'h006000, 24'h000D50, 1'b0);
        check_settled("post_reset");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            send_frame(24'h0000B8, 24'h006000, 24'h000D50, 1'b1);
            if (i == 253) check_settled("sat_254");
        end
        check_settled("saturate");
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_checksum();
        test_reserved();
        test_back_to_back();
        test_timeout();
        test_timeout_boundary();
        test_reset_midframe();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/param_loader.md
# param_loader

Receives a byte stream from the host link, assembles framed 18-bit fixed-point risk parameters (mu, S, sigma), and presents them atomically to the risk-calculation core inputs. It replaces static bench stimulus: in silicon, this block drives the core's iMu/iS/iSigma inputs. Each frame is validated by header, reserved-bit and checksum checks. Parameters update only on a fully valid frame.

## Interface
- TIMEOUT, 1000: max idle cycles between bytes inside a frame before abort
- CLK  input  1  system clock, all logic rising-edge
- RST  input  1  reset, asynchronous, active-high
- iByte  input  8  received byte
- iByteValid  input  1  one-cycle strobe, iByte valid
- oMu  output  18  mu parameter to core
- oS  output  18  S parameter to core
- oSigma  output  18  sigma parameter to core
- oLoad  output  1  one-cycle pulse, new parameter set on oMu/oS/oSigma
- oBusy  output  1  high while a frame is in progress (not HUNT)
- oErrCnt  output  8  rejected-frame count, saturating at 255

## Operation
- Frame, 11 bytes: header 0xA5; Mu[23:0], S[23:0], Sigma[23:0], each big-endian 3 bytes; checksum = XOR of the 9 payload bytes.
- Each 24-bit field carries an 18-bit value in bits [17:0]; bits [23:18] are reserved and must be 0.
- States: HUNT, PAYLOAD, CHECK.
  - HUNT: non-0xA5 bytes are discarded silently and are not errors. On 0xA5: go to PAYLOAD, byte index 0, running XOR 0.
  - PAYLOAD: each byte is shifted into a 72-bit shadow register and XORed into the checksum; index 0..8. 0xA5 here is ordinary data. After index 8, go to CHECK.
  - CHECK: the next byte is the checksum. The frame is good if checksum matches and all reserved bits are 0.
    - Good: copy the shadow register to oMu/oS/oSigma, pulse oLoad.
    - Bad: increment oErrCnt.
    - Either way, return to HUNT.
- Timeout: a gap counter resets on every accepted byte and counts while in PAYLOAD/CHECK. On reaching TIMEOUT with no byte: increment oErrCnt, return to HUNT, discard the shadow register.
- A byte strobe in the same cycle as timeout expiry wins; no timeout occurs.
- Outputs hold their last good value indefinitely. A bad or aborted frame never alters oMu/oS/oSigma.
- oErrCnt saturates at 255; it does not wrap.

## Timing
- Reset values: oMu=0, oS=0, oSigma=0, oLoad=0, oBusy=0, oErrCnt=0, state HUNT, gap counter 0.
- Asynchronous reset mid-frame: immediately returns to HUNT and clears everything. The partial frame is lost and not counted.
- Latency: oLoad is high for exactly one cycle, in the cycle after the checksum byte strobe. oMu/oS/oSigma change in that same cycle.
- oBusy rises the cycle after the header strobe and falls the cycle after the checksum strobe or timeout.
- oErrCnt updates the cycle after the checksum strobe or timeout expiry.
- Back-to-back strobes every cycle are supported. A header arriving in the cycle right after a checksum is accepted as the start of the next frame.
- Timeout expiry occurs TIMEOUT cycles after the last accepted in-frame byte.

## Structure
- Package param_loader_pkg:
  - FRAME_HDR = 8'hA5
  - PAYLOAD_BYTES = 9
  - PARAM_W = 18
  - state enum {HUNT, PAYLOAD, CHECK}
- Sub-module gap_timer:
  - Counter with clear and enable, parameter TIMEOUT; asserts expire for one cycle.
  - Counter width is $clog2(TIMEOUT+1).
- Top level holds the FSM, shadow register, XOR accumulator and output registers.

## Test plan
- Good frame A5 00 00 B8 00 60 00 00 0D 50 85 at one byte per cycle -> one oLoad pulse; oMu=184, oS=24576, oSigma=3408; oErrCnt=0.
- Same frame with checksum 0x84 -> no oLoad; outputs remain at reset 0; oErrCnt=1.
- Reserved bit set (Mu bytes 04 00 B8, checksum recomputed to 0x81) -> rejected; oErrCnt increments; outputs unchanged.
- Bytes 11 22 then good frame -> leading bytes ignored, oErrCnt=0, values loaded. Second frame with Mu=1 (checksum 0x3C) -> outputs update.
- TIMEOUT=16: header plus 4 payload bytes, then 16 idle cycles -> oErrCnt=1, oBusy=0. Next good frame still loads. Byte strobed on exactly the 16th idle cycle -> no error.
- Assert RST after byte 6 of a frame, release, send good frame -> oErrCnt=0, single oLoad with frame values. Also drive 300 bad frames -> oErrCnt saturates at 255.
